endp_packet_injector: RTL and testbench
=======================================

Name: endp_packet_injector

Overview:
- Endpoint-side packet injector; drives one local input channel of a mesh/torus/ring/line router (one `chan_in_all[i]` slot of the NoC top).
- Converts a packet request plus a streamed payload into head/body/tail flits on a selected virtual channel.
- Enforces credit-based flow control against the router's per-VC input buffers.
- Returns credits to the core side via ready handshakes; keeps packet statistics.

Parameters:
- V, 2: number of virtual channels.
- B, 4: router input buffer depth per VC, in flits; also the initial credit count.
- Fpay, 32: flit payload width.
- EAw, 4: endpoint address width.
- LENw, 8: packet length field width, in flits.
- Vw, derived, log2(V) (minimum 1): VC index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- src_addr  in  EAw  this endpoint's address, static.
- req_valid  in  1  packet request valid.
- req_ready  out  1  injector can accept a request.
- req_dest  in  EAw  destination endpoint address.
- req_len  in  LENw  packet length in flits, head included.
- req_vc  in  Vw  VC index for the packet.
- data_valid  in  1  payload word valid.
- data_ready  out  1  payload word accepted this cycle.
- data_in  in  Fpay  payload word.
- flit_wr  out  1  flit valid toward router.
- flit_hdr  out  1  head flit marker.
- flit_tail  out  1  tail flit marker.
- flit_vc  out  V  one-hot VC of the flit.
- flit_data  out  Fpay  flit payload.
- credit_in  in  V  one credit returned per asserted bit.
- busy  out  1  packet in progress.
- credit_err  out  1  sticky, credit overflow detected.
- sent_pck_cnt  out  16  completed packets, wraps.

Behaviour:
- Reset values:
  - all flit_* outputs 0; req_ready 1; data_ready 0; busy 0; credit_err 0; sent_pck_cnt 0.
  - every credit counter = B; FSM in IDLE.
  - Reset mid-packet aborts the packet; no tail flit is emitted.
- Credit counters:
  - One counter per VC, width log2(B+1).
  - "Issue" means an issue event on that VC in the current cycle.
  - Issue only: counter decrements.
  - credit_in bit only: counter increments.
  - Both in the same cycle: counter unchanged.
  - Increment at B: counter saturates at B and credit_err is set until reset.
- An issue requires credit[vc] > 0, which blocks at most one flit per cycle.
- All flit_* outputs are registered:
  - an issue in cycle t gives flit_wr = 1 in cycle t+1, for exactly one cycle;
  - flit_wr is 0 in all cycles without an issue.
- FSM IDLE:
  - req_ready = 1, busy = 0.
  - On req_valid & req_ready: latch dest, vc, len; go to HEAD.
  - Effective length: req_len = 0 is treated as 1.
- FSM HEAD:
  - req_ready = 0, busy = 1.
  - If credit[vc] > 0, issue the head flit with flit_hdr = 1.
  - Head flit_data fields:
    - [Fpay-1 : Fpay-EAw] = dest;
    - next EAw bits = src_addr;
    - [LENw-1 : 0] = effective length;
    - all other bits 0.
  - If length = 1: the same flit also has flit_tail = 1; go to IDLE.
  - Otherwise: load remaining = len-1; go to BODY.
  - Without credit: stay in HEAD.
- FSM BODY:
  - data_ready = (credit[vc] > 0), combinational; no dependence on data_valid.
  - On data_valid & data_ready: issue a flit carrying flit_data = data_in; decrement remaining.
  - When remaining = 1 at the issue: flit_tail = 1; go to IDLE.
  - data_ready = 0 in IDLE and HEAD.
- sent_pck_cnt increments in the cycle the tail is issued; it wraps modulo 2^16.
- Minimum gap between packets: one IDLE cycle, so a new request is accepted the cycle after the tail issue.
- The request-to-head latency is one cycle of HEAD when credit is available, so with credit:
  - request accepted in cycle t;
  - head issued in cycle t+1;
  - flit_wr high in cycle t+2.
- The VC is fixed for the whole packet; credit_in on other VCs is still counted.

Test Plan:
- Single-flit packet: req_len=1, dest=5, src=3, vc=1 → one flit with hdr=1, tail=1, flit_vc=2'b10, data[31:28]=5, data[27:24]=3, data[7:0]=1; credit[1] goes 4→3; sent_pck_cnt=1.
- Credit stall: 6-flit packet on vc0 with no credit_in → 4 flits emitted, then data_ready=0 and the FSM holds; one credit_in[0] pulse → exactly one more flit; a second pulse → tail, busy drops.
- Simultaneous issue and credit return on the same VC for 10 cycles → counter stays constant at its starting value; flit_wr is high every cycle.
- Overflow: credit_in[1] pulsed while credit[1]=4 → credit_err=1 and stays 1; counter stays 4.
- req_len=0 → handled as a 1-flit packet with the length field reading 1.
- Reset mid-packet, asserted after 2 of 5 flits → next cycle all outputs are at reset values, credits=4, req_ready=1; no tail is seen.

Source files
------------

// File: rtl/endp_packet_injector.sv
// Endpoint packet injector: turns a packet request plus a payload stream into
// head/body/tail flits on one router input channel under per-VC credit flow control.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for a packet request
//   ST_HEAD | request latched, waiting for a credit to issue the head flit
//   ST_BODY | streaming payload words as body flits until the tail is issued
module endp_packet_injector #(
    parameter int V    = 2,
    parameter int B    = 4,
    parameter int Fpay = 32,
    parameter int EAw  = 4,
    parameter int LENw = 8,
    parameter int Vw   = (V > 1) ? $clog2(V) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [EAw-1:0]    src_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [EAw-1:0]    req_dest,
    input  logic [LENw-1:0]   req_len,
    input  logic [Vw-1:0]     req_vc,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [Fpay-1:0]   data_in,
    output logic              flit_wr,
    output logic              flit_hdr,
    output logic              flit_tail,
    output logic [V-1:0]      flit_vc,
    output logic [Fpay-1:0]   flit_data,
    input  logic [V-1:0]      credit_in,
    output logic              busy,
    output logic              credit_err,
    output logic [15:0]       sent_pck_cnt
);

    localparam int CW = $clog2(B + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY
    } state_t;

    state_t            state_q, state_d;
    logic [EAw-1:0]    dest_q, dest_d;
    logic [Vw-1:0]     vc_q, vc_d;
    logic [LENw-1:0]   len_q, len_d;
    logic [LENw-1:0]   rem_q, rem_d;
    logic [CW-1:0]     credit_q [V];
    logic [CW-1:0]     credit_d [V];
    logic              credit_err_q, credit_err_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              flit_wr_q, flit_hdr_q, flit_tail_q;
    logic [V-1:0]      flit_vc_q;
    logic [Fpay-1:0]   flit_data_q;

    logic              issue, is_hdr, is_tail, cred_ok;
    logic [Fpay-1:0]   hdr_word, flit_data_d;
    logic [V-1:0]      vc_onehot;

    assign cred_ok = (credit_q[vc_q] != '0);

    always_comb begin
        hdr_word                        = '0;
        hdr_word[Fpay-1 -: EAw]         = dest_q;
        hdr_word[Fpay-EAw-1 -: EAw]     = src_addr;
        hdr_word[LENw-1:0]              = len_q;
    end

    always_comb begin
        vc_onehot = '0;
        for (int i = 0; i < V; i++) begin
            vc_onehot[i] = (vc_q == Vw'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        vc_d        = vc_q;
        len_d       = len_q;
        rem_d       = rem_q;
        req_ready   = 1'b0;
        busy        = 1'b0;
        data_ready  = 1'b0;
        issue       = 1'b0;
        is_hdr      = 1'b0;
        is_tail     = 1'b0;
        flit_data_d = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    dest_d  = req_dest;
                    vc_d    = req_vc;
                    len_d   = (req_len == '0) ? LENw'(1) : req_len;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                busy = 1'b1;
                if (cred_ok) begin
                    issue       = 1'b1;
                    is_hdr      = 1'b1;
                    flit_data_d = hdr_word;
                    if (len_q == LENw'(1)) begin
                        is_tail = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d   = len_q - 1'b1;
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                busy       = 1'b1;
                data_ready = cred_ok;
                if (data_valid && cred_ok) begin
                    issue       = 1'b1;
                    flit_data_d = data_in;
                    rem_d       = rem_q - 1'b1;
                    if (rem_q == LENw'(1)) begin
                        is_tail = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // An issue and a returned credit on the same VC in one cycle cancel out.
    always_comb begin
        credit_err_d = credit_err_q;
        for (int i = 0; i < V; i++) begin
            credit_d[i] = credit_q[i];
            if (issue && vc_onehot[i] && !credit_in[i]) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end else if (credit_in[i] && !(issue && vc_onehot[i])) begin
                if (credit_q[i] == CW'(B)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + 1'b1;
                end
            end
        end
    end

    assign cnt_d = (issue && is_tail) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dest_q       <= '0;
            vc_q         <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            credit_err_q <= 1'b0;
            cnt_q        <= '0;
            flit_wr_q    <= 1'b0;
            flit_hdr_q   <= 1'b0;
            flit_tail_q  <= 1'b0;
            flit_vc_q    <= '0;
            flit_data_q  <= '0;
            for (int i = 0; i < V; i++) begin
                credit_q[i] <= CW'(B);
            end
        end else begin
            state_q      <= state_d;
            dest_q       <= dest_d;
            vc_q         <= vc_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            credit_err_q <= credit_err_d;
            cnt_q        <= cnt_d;
            flit_wr_q    <= issue;
            flit_hdr_q   <= issue & is_hdr;
            flit_tail_q  <= issue & is_tail;
            flit_vc_q    <= issue ? vc_onehot : '0;
            flit_data_q  <= issue ? flit_data_d : '0;
            for (int i = 0; i < V; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign flit_wr      = flit_wr_q;
    assign flit_hdr     = flit_hdr_q;
    assign flit_tail    = flit_tail_q;
    assign flit_vc      = flit_vc_q;
    assign flit_data    = flit_data_q;
    assign credit_err   = credit_err_q;
    assign sent_pck_cnt = cnt_q;

endmodule

// File: tb/tb_endp_packet_injector.sv
// Bench for endp_packet_injector: packet-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_endp_packet_injector;

    localparam int V = 2;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_addr;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dest;
    logic [7:0]  req_len;
    logic [0:0]  req_vc;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data_in;
    logic        flit_wr;
    logic        flit_hdr;
    logic        flit_tail;
    logic [1:0]  flit_vc;
    logic [31:0] flit_data;
    logic [1:0]  credit_in;
    logic        busy;
    logic        credit_err;
    logic [15:0] sent_pck_cnt;

    endp_packet_injector #(.V(2), .B(4), .Fpay(32), .EAw(4), .LENw(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .src_addr     (src_addr),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dest     (req_dest),
        .req_len      (req_len),
        .req_vc       (req_vc),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .data_in      (data_in),
        .flit_wr      (flit_wr),
        .flit_hdr     (flit_hdr),
        .flit_tail    (flit_tail),
        .flit_vc      (flit_vc),
        .flit_data    (flit_data),
        .credit_in    (credit_in),
        .busy         (busy),
        .credit_err   (credit_err),
        .sent_pck_cnt (sent_pck_cnt)
    );

    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a packet is a count of flits sent so far against its length.
    bit          m_valid  = 1'b0;
    bit          m_active = 1'b0;
    int          m_len, m_done, m_vc;
    logic [3:0]  m_dest;
    int          cred [V];
    bit          m_err;
    int          m_cnt;
    logic        e_wr = 1'b0, e_hdr = 1'b0, e_tail = 1'b0;
    logic [1:0]  e_vc = '0;
    logic [31:0] e_data = '0;

    always @(posedge clk) begin
        bit          iss, tl, hd, take;
        logic [31:0] d;
        iss = 1'b0; tl = 1'b0; hd = 1'b0; d = '0;
        if (reset) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            for (int i = 0; i < V; i++) cred[i] = B;
            m_err = 1'b0;
            m_cnt = 0;
            e_wr = 1'b0; e_hdr = 1'b0; e_tail = 1'b0; e_vc = '0; e_data = '0;
        end else if (m_valid) begin
            if (!m_active) begin
                if (req_valid) begin
                    m_active = 1'b1;
                    m_len    = (req_len == 0) ? 1 : int'(req_len);
                    m_vc     = int'(req_vc);
                    m_dest   = req_dest;
                    m_done   = 0;
                end
            end else if (cred[m_vc] > 0 && (m_done == 0 || data_valid)) begin
                iss = 1'b1;
                hd  = (m_done == 0);
                d   = hd ? {m_dest, src_addr, 16'h0000, 8'(m_len)} : data_in;
                m_done++;
                tl  = (m_done == m_len);
            end
            for (int i = 0; i < V; i++) begin
                take = iss && (m_vc == i);
                if (take && !credit_in[i]) cred[i]--;
                else if (credit_in[i] && !take) begin
                    if (cred[i] == B) m_err = 1'b1;
                    else cred[i]++;
                end
            end
            if (iss && tl) begin
                m_cnt    = (m_cnt + 1) % 65536;
                m_active = 1'b0;
            end
            e_wr = iss; e_hdr = hd; e_tail = tl; e_data = d;
            e_vc = '0;
            if (iss) e_vc[m_vc] = 1'b1;
        end
    end

    int          flit_seen = 0;
    int          tail_seen = 0;
    logic [31:0] last_data;
    logic        last_hdr, last_tail;
    logic [1:0]  last_vc;

    always @(negedge clk) begin
        if (m_valid) begin
            check("req_ready", req_ready, !m_active);
            check("busy", busy, m_active);
            check("data_ready", data_ready, m_active && m_done > 0 && cred[m_vc] > 0);
            check("credit_err", credit_err, m_err);
            check("sent_pck_cnt", sent_pck_cnt, m_cnt);
            check("flit_wr", flit_wr, e_wr);
            if (e_wr) begin
                check("flit_hdr", flit_hdr, e_hdr);
                check("flit_tail", flit_tail, e_tail);
                check("flit_vc", flit_vc, e_vc);
                check("flit_data", flit_data, e_data);
            end
        end
        if (flit_wr === 1'b1) begin
            flit_seen++;
            if (flit_tail === 1'b1) tail_seen++;
            last_data = flit_data;
            last_hdr  = flit_hdr;
            last_tail = flit_tail;
            last_vc   = flit_vc;
        end
    end

    int cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        data_in = 32'hC0DE_0000 + 32'(cyc);
    endtask

    task automatic send_req(input logic [3:0] dest, input logic [7:0] len, input logic [0:0] vc);
        for (int k = 0; k < 50 && req_ready !== 1'b1; k++) tick();
        check("req_ready_wait", req_ready, 1);
        req_dest  = dest;
        req_len   = len;
        req_vc    = vc;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_flits(input int target, input int budget);
        for (int k = 0; k < budget && flit_seen < target; k++) tick();
        check("flit_wait", flit_seen >= target, 1);
    endtask

    initial begin
        int base, tails_before;
        reset = 1'b1; src_addr = 4'h3; req_valid = 1'b0; req_dest = '0; req_len = '0;
        req_vc = '0; data_valid = 1'b0; data_in = '0; credit_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_data_ready", data_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_flit_wr", flit_wr, 0);
        check("rst_sent", sent_pck_cnt, 0);

        // single-flit packet on vc1
        base = flit_seen;
        send_req(4'h5, 8'd1, 1'b1);
        wait_flits(base + 1, 10);
        check("single_data", last_data, 32'h5300_0001);
        check("single_hdr", last_hdr, 1);
        check("single_tail", last_tail, 1);
        check("single_vc", last_vc, 2'b10);
        tick();
        check("single_cnt", sent_pck_cnt, 1);

        // vc1 is at 3: first return is legal, second overflows
        credit_in = 2'b10; tick(); credit_in = '0; tick();
        check("ovf_not_yet", credit_err, 0);
        credit_in = 2'b10; tick(); credit_in = '0; tick();
        check("ovf_set", credit_err, 1);
        repeat (5) tick();
        check("ovf_sticky", credit_err, 1);

        // credit stall on vc0
        data_valid = 1'b1;
        base = flit_seen;
        send_req(4'h9, 8'd6, 1'b0);
        wait_flits(base + 4, 20);
        repeat (5) tick();
        check("stall_flits", flit_seen - base, 4);
        check("stall_data_ready", data_ready, 0);
        check("stall_busy", busy, 1);
        credit_in = 2'b01; tick(); credit_in = '0;
        repeat (5) tick();
        check("stall_one_more", flit_seen - base, 5);
        check("stall_busy2", busy, 1);
        credit_in = 2'b01; tick(); credit_in = '0;
        repeat (5) tick();
        check("stall_done", flit_seen - base, 6);
        check("stall_idle", busy, 0);
        check("stall_cnt", sent_pck_cnt, 2);
        credit_in = 2'b01; repeat (4) tick(); credit_in = '0; tick();

        // issue and return on vc1 together for 10 cycles
        base = flit_seen;
        send_req(4'h7, 8'd12, 1'b1);
        credit_in = 2'b10;
        repeat (10) tick();
        credit_in = '0;
        tick();
        check("simul_flits", flit_seen - base, 10);
        wait_flits(base + 12, 10);
        tick();
        check("simul_cnt", sent_pck_cnt, 3);

        // zero length behaves as one flit
        base = flit_seen;
        send_req(4'hA, 8'd0, 1'b0);
        wait_flits(base + 1, 10);
        check("len0_data", last_data, 32'hA300_0001);
        check("len0_hdr", last_hdr, 1);
        check("len0_tail", last_tail, 1);
        tick();
        check("len0_cnt", sent_pck_cnt, 4);

        // reset in the middle of a 5-flit packet
        base = flit_seen;
        tails_before = tail_seen;
        send_req(4'h2, 8'd5, 1'b0);
        wait_flits(base + 2, 20);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_flit_wr", flit_wr, 0);
        check("mid_rst_flit_vc", flit_vc, 0);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", credit_err, 0);
        check("mid_rst_cnt", sent_pck_cnt, 0);
        repeat (3) tick();
        check("mid_rst_no_tail", tail_seen - tails_before, 0);

        // credits back at 4 after reset: 6-flit packet stalls after 4
        base = flit_seen;
        send_req(4'h2, 8'd6, 1'b0);
        wait_flits(base + 4, 20);
        repeat (5) tick();
        check("post_rst_credits", flit_seen - base, 4);

        reset = 1'b1; repeat (2) tick(); reset = 1'b0; tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
